alpha_trim_mean: RTL
====================

# alpha_trim_mean

Consumes the rank-index vector produced by the parallel sorter for one 5x5 window and the same 25 pixel values. Discards the TRIM smallest and TRIM largest samples, sums the remaining samples serially, and divides by the kept count with a restoring divider. Emits one alpha-trimmed mean pixel per window. It sits directly downstream of the sorter in the Modified Alpha Mean Filter datapath.

## Interface
- DN, 25: samples per window
- DW, 8: sample width
- DWS, $clog2(DN) = 5: index width
- TRIM, 4: samples discarded at each end; legal range 0..(DN-1)/2
- NKEEP, DN-2*TRIM = 17: derived, kept samples
- SW, DW+$clog2(DN) = 13: derived, sum and divider width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; window data valid this cycle (same pulse that starts the sorter)
- data_in  in  DW*DN  unsorted window; sample i at [i*DW +: DW]
- seq_valid  in  1  sorter finish pulse
- seq_in  in  DWS*DN  slot k (k=0 smallest) at [k*DWS +: DWS] = original index of k-th smallest; stable from the cycle after seq_valid
- mean_out  out  DW  trimmed mean, held until next result
- mean_valid  out  1  one-cycle pulse, mean_out valid
- busy  out  1  high in every state except IDLE
- overrun  out  1  one-cycle pulse when start is seen while busy

## Operation
- States: IDLE, WAIT, LOAD, ACC, DIV, DONE.
- IDLE: on start, capture data_in into an internal buffer, clear the sum, go to WAIT. Otherwise stay.
- WAIT: on seq_valid go to LOAD. Otherwise stay indefinitely. There is no timeout.
- LOAD: capture seq_in into an internal register, set slot pointer k=TRIM, go to ACC.
- ACC: once per cycle, sum += buf[seq[k]], zero-extended to SW bits, then k++.
  - After slot DN-1-TRIM is added (NKEEP cycles total), go to DIV.
  - An index >= DN contributes 0.
- DIV: dividend = sum + floor(NKEEP/2), which gives round-half-up.
  - Restoring division by constant NKEEP, one quotient bit per cycle, MSB first, SW cycles.
  - Then go to DONE.
- DONE: mean_out <= quotient[DW-1:0]; mean_valid=1; go to IDLE.
- Arithmetic: max dividend = NKEEP*(2^DW-1)+NKEEP/2 < 2^SW, so there is no overflow. The quotient is always <= 2^DW-1, so no saturation is needed.
- start while busy: ignored. Buffer, sum and state are unaffected; overrun pulses the next cycle.
- start in DONE: counts as busy, so it is ignored and flagged.
- seq_valid outside WAIT: ignored.
- start and seq_valid in the same IDLE cycle: start is taken; that seq_valid is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs cleared. No pulse is generated for the aborted window.
- Reset values: mean_out=0, mean_valid=0, busy=0, overrun=0; internal sum, buffer, sequence and pointer are 0.

## Timing
- Let t be the cycle where seq_valid is high in WAIT. Then:
  - LOAD at t+1
  - ACC at t+2..t+1+NKEEP
  - DIV for the next SW cycles
  - mean_valid at t+2+NKEEP+SW, which is t+32 with the defaults
- busy drops in the cycle after mean_valid. A start in that cycle is accepted.
- Minimum window period, start to next accepted start = sorter latency + NKEEP + SW + 3 cycles.
- mean_out changes only on the mean_valid cycle.

## Test plan
- All 25 samples = 100, seq_in = identity -> mean_valid at exactly t+32, mean_out=100.
- data_in[i]=i, seq_in identity -> kept ranks 4..20, sum 204, (204+8)/17 -> mean_out=12.
- Outliers: 4x0, 16x10, 1x19, 4x200, shuffled, with a consistent seq_in.
  - Kept sum 179, (179+8)/17 -> mean_out=11, which checks rounding up.
  - Repeat with data reversed and seq_in reversed -> same result.
- All samples 255 -> sum 4335, no overflow, mean_out=255; back-to-back window with all 0 -> mean_out=0.
- start pulsed during ACC -> overrun pulses one cycle later, mean_out is unaffected, and exactly one mean_valid occurs.
- rst_n low during DIV -> busy=0, mean_out=0, no mean_valid. A fresh window afterwards completes normally with the correct value.

Source files
------------

// File: rtl/alpha_trim_mean.sv
// Alpha-trimmed mean of one 5x5 window: walks the sorter's rank vector, accumulates
// the kept ranks serially, then divides by the constant kept count with rounding.
module alpha_trim_mean #(
   parameter int DN    = 25,
   parameter int DW    = 8,
   parameter int DWS   = $clog2(DN),
   parameter int TRIM  = 4,
   parameter int NKEEP = DN - 2*TRIM,
   parameter int SW    = DW + $clog2(DN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DW*DN-1:0]  data_in,
   input  logic              seq_valid,
   input  logic [DWS*DN-1:0] seq_in,
   output logic [DW-1:0]     mean_out,
   output logic              mean_valid,
   output logic              busy,
   output logic              overrun
);
   // state | meaning
   // IDLE  | waiting for start; window buffer free
   // WAIT  | window captured, waiting for sorter finish pulse
   // LOAD  | capture rank vector, point at first kept slot
   // ACC   | add one kept sample per cycle
   // DIV   | restoring division by NKEEP, one quotient bit per cycle
   // DONE  | result presented for one cycle
   typedef enum logic [2:0] {IDLE, WAIT, LOAD, ACC, DIV, DONE} state_t;

   localparam int CW = $clog2(SW);
   localparam logic [DWS-1:0] K_FIRST = DWS'(TRIM);
   localparam logic [DWS-1:0] K_LAST  = DWS'(DN - 1 - TRIM);
   localparam logic [SW:0]    DIVISOR = (SW+1)'(NKEEP);
   localparam logic [SW-1:0]  HALF    = SW'(NKEEP / 2);
   localparam logic [CW-1:0]  C_LAST  = CW'(SW - 1);

   state_t         state;
   logic [DW-1:0]  smp   [DN];
   logic [DWS-1:0] seq_q [DN];
   logic [DWS-1:0] k;
   logic [CW-1:0]  cnt;
   logic [SW-1:0]  sum;
   logic [SW-1:0]  quo;
   logic [SW-1:0]  rem;

   logic [DWS-1:0] sel;
   logic [DW-1:0]  addend;
   logic [SW-1:0]  sum_next;
   logic [SW:0]    trial;
   logic [SW:0]    diff;
   logic [SW-1:0]  quo_next;
   logic [SW-1:0]  rem_next;

   always_comb begin
      sel      = seq_q[k];
      addend   = (int'(sel) < DN) ? smp[sel] : '0;
      sum_next = sum + SW'(addend);
      // remainder never reaches NKEEP, so a borrow-out is the restore decision
      trial    = {rem, quo[SW-1]};
      diff     = trial - DIVISOR;
      if (!diff[SW]) begin
         rem_next = diff[SW-1:0];
         quo_next = {quo[SW-2:0], 1'b1};
      end else begin
         rem_next = trial[SW-1:0];
         quo_next = {quo[SW-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mean_out   <= '0;
         mean_valid <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         k          <= '0;
         cnt        <= '0;
         sum        <= '0;
         quo        <= '0;
         rem        <= '0;
         for (int i = 0; i < DN; i++) begin
            smp[i]   <= '0;
            seq_q[i] <= '0;
         end
      end else begin
         mean_valid <= 1'b0;
         overrun    <= start && (state != IDLE);
         case (state)
            IDLE: if (start) begin
               for (int i = 0; i < DN; i++) smp[i] <= data_in[i*DW +: DW];
               sum   <= '0;
               busy  <= 1'b1;
               state <= WAIT;
            end
            WAIT: if (seq_valid) state <= LOAD;
            LOAD: begin
               for (int i = 0; i < DN; i++) seq_q[i] <= seq_in[i*DWS +: DWS];
               k     <= K_FIRST;
               state <= ACC;
            end
            ACC: begin
               sum <= sum_next;
               k   <= k + 1'b1;
               if (k == K_LAST) begin
                  quo   <= sum_next + HALF;
                  rem   <= '0;
                  cnt   <= '0;
                  state <= DIV;
               end
            end
            DIV: begin
               quo <= quo_next;
               rem <= rem_next;
               cnt <= cnt + 1'b1;
               if (cnt == C_LAST) begin
                  mean_out   <= quo_next[DW-1:0];
                  mean_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
